// File: rtl/spi_flash_read_seq.sv
// Single-word SPI flash read sequencer: opcode, address bytes and four read slots go to the
// byte-level command engine, and the returned bytes are assembled into one 32-bit response.
module spi_flash_read_seq #(
  parameter logic [7:0] READ_OPCODE    = 8'h03,
  parameter int         ADDR_BYTES     = 3,
  parameter int         TIMEOUT_CYCLES = 4096
) (
  input  logic        spi_clk,
  input  logic        spi_reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic        rsp_err,
  output logic        cmd_valid,
  input  logic        cmd_ready,
  output logic [7:0]  cmd_wdata,
  output logic        cmd_rd,
  output logic        cmd_last,
  input  logic        cmd_rvalid,
  input  logic [7:0]  cmd_rdata,
  input  logic        cmd_done,
  output logic [3:0]  state
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [3:0] {
    IDLE           = 4'b0000,
    SEND_CODE_ADDR = 4'b0001,
    READ_WAIT      = 4'b0010,
    WRITE_DATA     = 4'b0011,
    FINISH_DONE    = 4'b0100
  } state_t;

  state_t         state_q;
  logic [31:0]    addr_q;
  logic [31:0]    data_q;
  logic [2:0]     slot_cnt;
  logic [2:0]     rd_cnt;
  logic [TW-1:0]  timer;

  logic           cmd_hs;
  logic           busy;
  logic           last_slot;
  logic           final_byte;
  logic           activity;
  logic           early_done;
  logic           timed_out;
  logic           abort_now;
  logic [7:0]     next_addr_byte;

  assign rsp_data = data_q;
  assign state    = state_q;

  // Any handshake, byte or closing pulse counts as engine progress and restarts the timeout.
  always_comb begin
    cmd_hs         = cmd_valid && cmd_ready;
    busy           = state_q inside {SEND_CODE_ADDR, READ_WAIT, FINISH_DONE};
    last_slot      = (slot_cnt == 3'(ADDR_BYTES));
    final_byte     = (state_q == READ_WAIT) && cmd_rvalid && (rd_cnt == 3'd3);
    activity       = cmd_hs
                   || ((state_q == READ_WAIT) && cmd_rvalid)
                   || ((state_q == FINISH_DONE) && cmd_done);
    early_done     = cmd_done && !final_byte
                   && ((state_q == SEND_CODE_ADDR) || (state_q == READ_WAIT));
    timed_out      = busy && !activity && (timer == TW'(TIMEOUT_CYCLES - 1));
    abort_now      = early_done || timed_out;
    next_addr_byte = 8'(addr_q >> (8 * (ADDR_BYTES - 1 - int'(slot_cnt))));
  end

  always_ff @(posedge spi_clk or posedge spi_reset) begin
    if (spi_reset) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      data_q    <= '0;
      slot_cnt  <= '0;
      rd_cnt    <= '0;
      timer     <= '0;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      cmd_valid <= 1'b0;
      cmd_wdata <= '0;
      cmd_rd    <= 1'b0;
      cmd_last  <= 1'b0;
    end else begin
      if (busy) begin
        timer <= activity ? '0 : timer + 1'b1;
      end

      if (abort_now) begin
        // Failed transaction: report an error word of zero and stop talking to the engine.
        state_q   <= WRITE_DATA;
        data_q    <= '0;
        rsp_err   <= 1'b1;
        rsp_valid <= 1'b1;
        cmd_valid <= 1'b0;
        cmd_wdata <= '0;
        cmd_rd    <= 1'b0;
        cmd_last  <= 1'b0;
        timer     <= '0;
      end else begin
        case (state_q)
          IDLE: begin
            if (req_valid && req_ready) begin
              addr_q    <= req_addr & 32'hFFFF_FFFC;
              data_q    <= '0;
              slot_cnt  <= '0;
              rd_cnt    <= '0;
              timer     <= '0;
              rsp_err   <= 1'b0;
              req_ready <= 1'b0;
              cmd_valid <= 1'b1;
              cmd_wdata <= READ_OPCODE;
              cmd_rd    <= 1'b0;
              cmd_last  <= 1'b0;
              state_q   <= SEND_CODE_ADDR;
            end
          end

          SEND_CODE_ADDR: begin
            if (cmd_hs) begin
              if (last_slot) begin
                // The first read slot follows the last address byte without a bubble.
                cmd_rd    <= 1'b1;
                cmd_wdata <= '0;
                cmd_last  <= 1'b0;
                rd_cnt    <= '0;
                state_q   <= READ_WAIT;
              end else begin
                slot_cnt  <= slot_cnt + 1'b1;
                cmd_wdata <= next_addr_byte;
              end
            end
          end

          READ_WAIT: begin
            if (cmd_rvalid) begin
              data_q <= {cmd_rdata, data_q[31:8]};
              if (rd_cnt == 3'd3) begin
                cmd_valid <= 1'b0;
                cmd_last  <= 1'b0;
                if (cmd_done) begin
                  rsp_valid <= 1'b1;
                  state_q   <= WRITE_DATA;
                end else begin
                  state_q   <= FINISH_DONE;
                end
              end else begin
                rd_cnt    <= rd_cnt + 1'b1;
                cmd_valid <= 1'b1;
                cmd_last  <= (rd_cnt == 3'd2);
              end
            end else if (cmd_hs) begin
              cmd_valid <= 1'b0;
            end
          end

          FINISH_DONE: begin
            if (cmd_done) begin
              rsp_valid <= 1'b1;
              cmd_rd    <= 1'b0;
              state_q   <= WRITE_DATA;
            end
          end

          WRITE_DATA: begin
            if (rsp_valid && rsp_ready) begin
              rsp_valid <= 1'b0;
              req_ready <= 1'b1;
              cmd_rd    <= 1'b0;
              state_q   <= IDLE;
            end
          end

          default: begin
            state_q   <= IDLE;
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            cmd_valid <= 1'b0;
            cmd_rd    <= 1'b0;
            cmd_last  <= 1'b0;
            timer     <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_spi_flash_read_seq.sv
// Randomized bench for spi_flash_read_seq: two instances (3 and 4 address bytes) driven by a
// cycle-level engine model, with expected slot bytes and response words built from the read rules.
module tb_spi_flash_read_seq;

  localparam int NORMAL = 0;
  localparam int TMO    = 1;
  localparam int EARLY  = 2;
  localparam int ABORT  = 3;

  logic        spi_clk = 1'b0;
  logic        spi_reset;
  logic        req_valid[2];
  logic        req_ready[2];
  logic [31:0] req_addr[2];
  logic        rsp_valid[2];
  logic        rsp_ready[2];
  logic [31:0] rsp_data[2];
  logic        rsp_err[2];
  logic        cmd_valid[2];
  logic        cmd_ready[2];
  logic [7:0]  cmd_wdata[2];
  logic        cmd_rd[2];
  logic        cmd_last[2];
  logic        cmd_rvalid[2];
  logic [7:0]  cmd_rdata[2];
  logic        cmd_done[2];
  logic [3:0]  state[2];

  int checks = 0;
  int fails  = 0;

  always #5 spi_clk = ~spi_clk;

  spi_flash_read_seq #(.READ_OPCODE(8'h03), .ADDR_BYTES(3), .TIMEOUT_CYCLES(16)) dut3 (
    .spi_clk(spi_clk), .spi_reset(spi_reset),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_addr(req_addr[0]),
    .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]), .rsp_data(rsp_data[0]), .rsp_err(rsp_err[0]),
    .cmd_valid(cmd_valid[0]), .cmd_ready(cmd_ready[0]), .cmd_wdata(cmd_wdata[0]), .cmd_rd(cmd_rd[0]),
    .cmd_last(cmd_last[0]), .cmd_rvalid(cmd_rvalid[0]), .cmd_rdata(cmd_rdata[0]), .cmd_done(cmd_done[0]),
    .state(state[0])
  );

  spi_flash_read_seq #(.READ_OPCODE(8'h03), .ADDR_BYTES(4), .TIMEOUT_CYCLES(16)) dut4 (
    .spi_clk(spi_clk), .spi_reset(spi_reset),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_addr(req_addr[1]),
    .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]), .rsp_data(rsp_data[1]), .rsp_err(rsp_err[1]),
    .cmd_valid(cmd_valid[1]), .cmd_ready(cmd_ready[1]), .cmd_wdata(cmd_wdata[1]), .cmd_rd(cmd_rd[1]),
    .cmd_last(cmd_last[1]), .cmd_rvalid(cmd_rvalid[1]), .cmd_rdata(cmd_rdata[1]), .cmd_done(cmd_done[1]),
    .state(state[1])
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge spi_clk);
      for (int j = 0; j < 2; j++) begin
        req_valid[j]  = 1'b0;
        cmd_rvalid[j] = 1'b0;
        cmd_done[j]   = 1'b0;
      end
    end
  endtask

  // Stray engine strobes while idle must not leak into the next read.
  task automatic strayBytes(input int s);
    for (int i = 0; i < 4; i++) begin
      @(negedge spi_clk);
      cmd_rvalid[s] = 1'b1;
      cmd_rdata[s]  = 8'($urandom);
      cmd_done[s]   = (i == 1);
    end
    @(negedge spi_clk);
    cmd_rvalid[s] = 1'b0;
    cmd_done[s]   = 1'b0;
  endtask

  // One read request on instance s, with the engine modelled cycle by cycle.
  task automatic applyStimulus(input int s, input logic [31:0] addr, input logic [31:0] ret_word,
                               input int mode, input int bt, input int hold, input bit rdy_rand,
                               input bit b2b, input logic [31:0] next_addr, input bit ready_now);
    int nab, cyc, nslot, nrecv, rv_t, dn_t, hold_left, last_act, d;
    bit accepted, finished, outstanding, rsp_seen, fire, hs_rd, held_err;
    logic [31:0] a, held_data, exp_word;
    logic [7:0]  ab[4];
    logic [7:0]  ret[4];
    logic [7:0]  exp_byte[$];
    bit          exp_rd[$];
    bit          exp_last[$];

    nab = (s == 0) ? 3 : 4;
    a = {addr[31:2], 2'b00};
    ab[0] = a[31:24]; ab[1] = a[23:16]; ab[2] = a[15:8]; ab[3] = a[7:0];
    exp_byte.push_back(8'h03); exp_rd.push_back(1'b0); exp_last.push_back(1'b0);
    for (int k = 4 - nab; k < 4; k++) begin
      exp_byte.push_back(ab[k]); exp_rd.push_back(1'b0); exp_last.push_back(1'b0);
    end
    for (int k = 0; k < 4; k++) begin
      exp_byte.push_back(8'h00); exp_rd.push_back(1'b1); exp_last.push_back(k == 3);
      ret[k] = ret_word[8*k +: 8];
    end
    exp_word = {ret[3], ret[2], ret[1], ret[0]};

    cyc = 0; nslot = 0; nrecv = 0; rv_t = 0; dn_t = 0; hold_left = hold; last_act = 0;
    accepted = 0; finished = 0; outstanding = 0; rsp_seen = 0; held_err = 0; held_data = '0;
    req_addr[s]  = addr;
    req_valid[s] = 1'b1;

    while (!finished && cyc < 300) begin
      @(negedge spi_clk);
      cyc++;
      if (accepted) req_valid[s] = b2b && rsp_seen;
      if (b2b && rsp_seen) req_addr[s] = next_addr;
      cmd_rvalid[s] = 1'b0;
      cmd_done[s]   = 1'b0;
      fire = 0;
      if (dn_t > 0) begin
        dn_t--;
        if (dn_t == 0) cmd_done[s] = 1'b1;
      end
      if (rv_t > 0) begin
        rv_t--;
        if (rv_t == 0) begin
          fire = 1;
          cmd_rvalid[s] = 1'b1;
          cmd_rdata[s]  = ret[nrecv];
          nrecv++;
          last_act = cyc;
          if (mode == EARLY && nrecv == 2) dn_t = 1;
          if (mode == NORMAL && nrecv == 4) begin
            d = $urandom_range(0, 3);
            if (d == 0) cmd_done[s] = 1'b1;
            else dn_t = d;
          end
        end
      end
      cmd_ready[s] = rdy_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
      if (rsp_valid[s] && hold_left > 0) begin
        rsp_ready[s] = 1'b0;
        hold_left--;
      end else begin
        rsp_ready[s] = 1'b1;
      end

      if (mode == ABORT && nrecv >= 1 && cmd_valid[s]) begin
        #2 spi_reset = 1'b1;
        #1;
        checkOutput("abort_state", 32'(state[s]), 32'd0);
        checkOutput("abort_cmd_valid", 32'(cmd_valid[s]), 32'd0);
        checkOutput("abort_rsp_valid", 32'(rsp_valid[s]), 32'd0);
        checkOutput("abort_req_ready", 32'(req_ready[s]), 32'd1);
        cmd_rvalid[s] = 1'b0;
        req_valid[s]  = 1'b0;
        finished = 1;
      end else begin
        if (!accepted) begin
          if (ready_now && cyc == 1) checkOutput("req_ready_after_rsp", 32'(req_ready[s]), 32'd1);
          if (req_ready[s]) accepted = 1;
        end else begin
          checkOutput("req_ready_busy", 32'(req_ready[s]), 32'd0);
        end

        hs_rd = 0;
        if (cmd_valid[s] && cmd_ready[s]) begin
          if (nslot < exp_byte.size()) begin
            checkOutput($sformatf("slot%0d_wdata", nslot), 32'(cmd_wdata[s]), 32'(exp_byte[nslot]));
            checkOutput($sformatf("slot%0d_rd", nslot), 32'(cmd_rd[s]), 32'(exp_rd[nslot]));
            checkOutput($sformatf("slot%0d_last", nslot), 32'(cmd_last[s]), 32'(exp_last[nslot]));
          end else begin
            checkOutput("extra_slot", 32'(nslot), 32'(exp_byte.size()));
          end
          if (cmd_rd[s]) begin
            checkOutput("one_outstanding", 32'(outstanding), 32'd0);
            hs_rd = 1;
            if (mode != TMO) rv_t = (bt > 0) ? bt : $urandom_range(1, 3);
          end
          nslot++;
          last_act = cyc;
        end
        if (hs_rd) outstanding = 1;
        else if (fire) outstanding = 0;

        if (rsp_valid[s]) begin
          if (!rsp_seen) begin
            rsp_seen  = 1;
            held_data = rsp_data[s];
            held_err  = rsp_err[s];
            if (mode == NORMAL) begin
              checkOutput("rsp_data", rsp_data[s], exp_word);
              checkOutput("rsp_err", 32'(rsp_err[s]), 32'd0);
              checkOutput("slot_count", 32'(nslot), 32'(exp_byte.size()));
            end else begin
              checkOutput("err_rsp_data", rsp_data[s], 32'd0);
              checkOutput("err_rsp_err", 32'(rsp_err[s]), 32'd1);
              checkOutput("err_cmd_valid", 32'(cmd_valid[s]), 32'd0);
            end
            if (mode == TMO)
              checkOutput("timeout_window", 32'((cyc - last_act) >= 16 && (cyc - last_act) <= 17), 32'd1);
          end else begin
            checkOutput("rsp_data_stable", rsp_data[s], held_data);
            checkOutput("rsp_err_stable", 32'(rsp_err[s]), 32'(held_err));
          end
          if (rsp_ready[s]) finished = 1;
        end
      end
    end
    checkOutput("cycle_budget", 32'(finished), 32'd1);
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [31:0] nxt;
    spi_reset = 1'b1;
    for (int j = 0; j < 2; j++) begin
      req_valid[j] = 1'b0; req_addr[j] = '0; rsp_ready[j] = 1'b0; cmd_ready[j] = 1'b0;
      cmd_rvalid[j] = 1'b0; cmd_rdata[j] = '0; cmd_done[j] = 1'b0;
    end
    repeat (3) @(negedge spi_clk);
    for (int j = 0; j < 2; j++) begin
      checkOutput("reset_state", 32'(state[j]), 32'd0);
      checkOutput("reset_req_ready", 32'(req_ready[j]), 32'd1);
      checkOutput("reset_cmd_valid", 32'(cmd_valid[j]), 32'd0);
      checkOutput("reset_rsp_valid", 32'(rsp_valid[j]), 32'd0);
      checkOutput("reset_rsp_data", rsp_data[j], 32'd0);
      checkOutput("reset_rsp_err", 32'(rsp_err[j]), 32'd0);
      checkOutput("reset_cmd_last", 32'(cmd_last[j]), 32'd0);
    end
    spi_reset = 1'b0;
    idleCycles(2);

    $display("[TB] basic read, 3 address bytes");
    applyStimulus(0, 32'h0012_3456, 32'hDDCC_BBAA, NORMAL, 2, 0, 1'b0, 1'b0, 32'h0, 1'b0);
    idleCycles(2);

    $display("[TB] stalled response with a queued second request");
    nxt = $urandom;
    applyStimulus(0, 32'h0012_3456, 32'hDDCC_BBAA, NORMAL, 2, 5, 1'b0, 1'b1, nxt, 1'b0);
    applyStimulus(0, nxt, $urandom, NORMAL, 2, 0, 1'b0, 1'b0, 32'h0, 1'b1);
    idleCycles(2);

    $display("[TB] four address bytes");
    applyStimulus(1, 32'h0102_0304, $urandom, NORMAL, 0, 0, 1'b1, 1'b0, 32'h0, 1'b0);
    idleCycles(2);

    $display("[TB] engine timeout");
    applyStimulus(0, $urandom, $urandom, TMO, 2, 0, 1'b1, 1'b0, 32'h0, 1'b0);
    idleCycles(2);

    $display("[TB] early cmd_done then stray strobes");
    applyStimulus(0, $urandom, $urandom, EARLY, 2, 0, 1'b0, 1'b0, 32'h0, 1'b0);
    idleCycles(2);
    strayBytes(0);
    applyStimulus(0, $urandom, 32'h1234_5678, NORMAL, 2, 0, 1'b0, 1'b0, 32'h0, 1'b0);
    idleCycles(2);

    $display("[TB] reset during READ_WAIT");
    applyStimulus(0, $urandom, $urandom, ABORT, 2, 0, 1'b0, 1'b0, 32'h0, 1'b0);
    idleCycles(2);
    spi_reset = 1'b0;
    idleCycles(1);
    checkOutput("post_reset_state", 32'(state[0]), 32'd0);
    applyStimulus(0, $urandom, $urandom, NORMAL, 0, 0, 1'b0, 1'b0, 32'h0, 1'b0);
    idleCycles(2);

    $display("[TB] randomized reads");
    for (int i = 0; i < 20; i++) begin
      applyStimulus($urandom_range(0, 1), $urandom, $urandom, NORMAL, 0, $urandom_range(0, 3),
                    1'b1, 1'b0, 32'h0, 1'b0);
      idleCycles($urandom_range(1, 3));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
